// File: rtl/data_memory_bank.sv
// Byte-addressed data memory for the load/store stage: one request per cycle,
// in-order responses after a fixed READ_LATENCY, self-clearing to INIT_VALUE after reset.

module data_memory_lane #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module data_memory_bank #(
  parameter int          DEPTH        = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH);
  localparam int IW        = ADDR_WIDTH - 2;

  localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);
  localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);
  localparam logic [NUM_LANES-1:0][7:0] INIT_B = INIT_VALUE;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } rsp_t;

  logic          state;
  logic [AW-1:0] cnt;
  logic          init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_ROW) state <= ST_RUN;
    end
  end

  assign init      = (state == ST_INIT);
  assign req_ready = (state == ST_RUN);

  // Request decode
  logic                          acc;
  logic [IW-1:0]                 idx;
  logic [1:0]                    lane;
  logic [AW-1:0]                 row;
  logic                          fault;
  logic [NUM_LANES-1:0]          be;
  logic [NUM_LANES-1:0][7:0]     st_data;
  logic [NUM_LANES-1:0][7:0]     rword;

  assign acc  = req_valid & req_ready;
  assign idx  = req_addr[ADDR_WIDTH-1:2];
  assign lane = req_addr[1:0];
  assign row  = idx[AW-1:0];

  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = lane[0];
      2'b10:   fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
    if (idx >= DEPTH_IDX) fault = 1'b1;
  end

  // Store data is replicated across lanes; the byte enables pick where it lands.
  always_comb begin
    be      = '0;
    st_data = req_wdata;
    case (req_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic          we;
      logic [AW-1:0] waddr;
      logic [7:0]    wdata;

      // INIT sweep owns the write port; requests are never accepted then.
      assign we    = init | (acc & req_write & ~fault & be[gi]);
      assign waddr = init ? cnt : row;
      assign wdata = init ? INIT_B[gi] : st_data[gi];

      data_memory_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (row),
        .rdata (rword[gi])
      );
    end
  endgenerate

  // Load lane select and extension
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ld_data;

  assign sel_b = rword[lane];
  assign sel_h = lane[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};

  always_comb begin
    case (req_size)
      2'b00:   ld_data = {{24{req_signed & sel_b[7]}}, sel_b};
      2'b01:   ld_data = {{16{req_signed & sel_h[15]}}, sel_h};
      default: ld_data = rword;
    endcase
  end

  rsp_t rsp_in;

  always_comb begin
    rsp_in.fault = acc & fault;
    rsp_in.data  = (acc & ~req_write & ~fault) ? ld_data : 32'h0;
  end

  // Response pipeline: stage 0 is the request being accepted this cycle.
  logic [READ_LATENCY:1]           vld_q;
  rsp_t [READ_LATENCY:1]           rsp_q;
  logic [READ_LATENCY:0]           vld_pipe;
  rsp_t [READ_LATENCY:0]           rsp_pipe;

  assign vld_pipe = {vld_q, acc};
  assign rsp_pipe = {rsp_q, rsp_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rsp_q <= '0;
    end else begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      rsp_q <= rsp_pipe[READ_LATENCY-1:0];
    end
  end

  assign rsp_valid = vld_pipe[READ_LATENCY];
  assign rsp_fault = rsp_pipe[READ_LATENCY].fault;
  assign rsp_rdata = rsp_pipe[READ_LATENCY].data;
endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank: byte-array reference model, in-order
// response scoreboard with latency check, mid-stream reset.

module tb_data_memory_bank;
  localparam int          DEPTH = 8;
  localparam int          RL    = 3;
  localparam logic [31:0] INIT  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  data_memory_bank #(
    .DEPTH(DEPTH), .ADDR_WIDTH(32), .READ_LATENCY(RL), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Reference model: little-endian byte array
  logic [7:0] mb [4*DEPTH];

  function automatic void model_reset();
    logic [31:0] iv;
    iv = INIT;
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = iv[8*(i%4) +: 8];
  endfunction

  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic f, output logic [31:0] d);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    d  = '0;
    if (sz == 2'b11)                 f = 1'b1;
    else if ((a % nb) != 0)          f = 1'b1;
    else if (a >= 32'(4*DEPTH))      f = 1'b1;
    else                             f = 1'b0;
    if (!f) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mb[a+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (32'(mb[a+k]) << (8*k));
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        d = v;
      end
    end
  endfunction

  typedef struct {
    logic        f;
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t ce;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
        end else begin
          ce = q.pop_front();
          chk("rsp_cycle", cyc, ce.due);
          chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, ce.f});
          chk("rsp_rdata", rsp_rdata, ce.d);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missing_rsp: got rsp_valid=0 at cycle %0d expected response due %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic do_req(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic lit_en, input logic lit_f, input logic [31:0] lit_d);
    logic f;
    logic [31:0] d;
    exp_t e;
    @(negedge clk);
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    model(w, sz, sg, a, wd, f, d);
    if (lit_en) begin
      chk({nm, "_model_fault"}, {31'b0, f}, {31'b0, lit_f});
      chk({nm, "_model_data"}, d, lit_d);
    end
    e.f = f; e.d = d; e.due = cyc + RL;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic reset_and_init();
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 4*DEPTH; i++) begin
      @(negedge clk);
      if (req_ready) begin
        n = i;
        break;
      end
    end
    chk("init_ready_cycles", n, DEPTH);
  endtask

  initial begin
    reset_and_init();

    // INIT contents
    do_req("lw_init",   0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'h1234_5678);
    do_req("lbu_init",  0, 2'b00, 0, 32'h00, 0, 1, 0, 32'h0000_0078);
    do_req("lh_init",   0, 2'b01, 1, 32'h02, 0, 1, 0, 32'h0000_1234);

    // Store/load with lane select and extension, back-to-back for read-after-write
    do_req("sw_c",      1, 2'b10, 0, 32'h0C, 32'hDEAD_BEEF, 1, 0, 32'h0);
    do_req("lw_c",      0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'hDEAD_BEEF);
    do_req("sb_d",      1, 2'b00, 0, 32'h0D, 32'hFFFF_FF7F, 1, 0, 32'h0);
    do_req("lb_d",      0, 2'b00, 1, 32'h0D, 0, 1, 0, 32'h0000_007F);
    do_req("lw_c2",     0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'hDEAD_7FEF);
    do_req("lbu_f",     0, 2'b00, 0, 32'h0F, 0, 1, 0, 32'h0000_00DE);
    do_req("lb_c",      0, 2'b00, 1, 32'h0C, 0, 1, 0, 32'hFFFF_FFEF);
    do_req("lh_e",      0, 2'b01, 1, 32'h0E, 0, 1, 0, 32'hFFFF_DEAD);
    do_req("lhu_e",     0, 2'b01, 0, 32'h0E, 0, 1, 0, 32'h0000_DEAD);

    // Faults
    do_req("lh_mis",    0, 2'b01, 1, 32'h0D, 0, 1, 1, 32'h0);
    do_req("sw_mis",    1, 2'b10, 0, 32'h0E, 32'h1111_1111, 1, 1, 32'h0);
    do_req("lw_c3",     0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'hDEAD_7FEF);
    do_req("lw_oor",    0, 2'b10, 0, 32'(4*DEPTH), 0, 1, 1, 32'h0);
    do_req("sw_alias",  1, 2'b10, 0, 32'h8000_000C, 32'h5555_5555, 1, 1, 32'h0);
    do_req("size3",     0, 2'b11, 0, 32'h00, 0, 1, 1, 32'h0);
    do_req("lw_c4",     0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'hDEAD_7FEF);

    // Half store into upper lanes, then last word
    do_req("sh_12",     1, 2'b01, 0, 32'h12, 32'h0000_ABCD, 1, 0, 32'h0);
    do_req("lw_10",     0, 2'b10, 0, 32'h10, 0, 1, 0, 32'hABCD_5678);
    do_req("sw_last",   1, 2'b10, 0, 32'(4*DEPTH-4), 32'hCAFE_F00D, 0, 0, 32'h0);
    do_req("lh_last",   0, 2'b01, 1, 32'(4*DEPTH-2), 0, 1, 0, 32'hFFFF_CAFE);
    idle();

    // Four back-to-back loads with a gap before them
    repeat (3) @(negedge clk);
    do_req("bb0", 0, 2'b10, 0, 32'h00, 0, 0, 0, 32'h0);
    do_req("bb1", 0, 2'b10, 0, 32'h0C, 0, 0, 0, 32'h0);
    do_req("bb2", 0, 2'b00, 1, 32'h0F, 0, 0, 0, 32'h0);
    do_req("bb3", 0, 2'b10, 0, 32'h10, 0, 0, 0, 32'h0);
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain_stream", q.size(), 0);

    // Reset with loads in flight: first response seen, rest must be dropped
    do_req("mid0", 0, 2'b10, 0, 32'h0C, 0, 0, 0, 32'h0);
    do_req("mid1", 0, 2'b10, 0, 32'h10, 0, 0, 0, 32'h0);
    do_req("mid2", 0, 2'b10, 0, 32'h00, 0, 0, 0, 32'h0);
    idle();
    #2;
    reset_and_init();
    repeat (RL + 2) @(negedge clk);
    do_req("lw_reinit", 0, 2'b10, 0, 32'h0C, 0, 1, 0, 32'h1234_5678);
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain_final", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end
endmodule
